// File: rtl/np_fetch.sv
// Instruction fetch stage for the np core: issues sequential reads, buffers returned
// words in a small prefetch queue and hands them to execute over valid/ready.
module np_fetch #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_rd,
    output logic [ADDRSIZE-1:0] mem_addr,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic [WIDTH-1:0]    ir,
    output logic [ADDRSIZE-1:0] ir_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    input  logic                br_taken,
    input  logic [ADDRSIZE-1:0] br_target,
    output logic                halt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] OP_HLT = 4'b1011;

    logic [ADDRSIZE-1:0] pc;
    logic [ADDRSIZE-1:0] inflight_addr;
    logic                inflight;
    logic                stopped;
    logic [WIDTH-1:0]    q_data [DEPTH];
    logic [ADDRSIZE-1:0] q_pc   [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       occupancy;
    logic                pop;
    logic                push;

    assign ir_valid = (count != '0);
    assign ir       = q_data[rd_ptr];
    assign ir_pc    = q_pc[rd_ptr];
    assign pop      = ir_valid && ir_ready && !br_taken;
    assign push     = inflight && !br_taken;

    // Slots already claimed once this cycle's pop is accounted for; a new read
    // may only be issued if its returning word is guaranteed a queue entry.
    assign occupancy = count + CW'(inflight) - CW'(pop);
    assign mem_rd    = reset && !stopped && !br_taken && (occupancy < CW'(DEPTH));
    assign mem_addr  = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            stopped       <= 1'b0;
            halt          <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (br_taken) begin
            // Redirect drops everything, including the word returning this cycle.
            pc       <= br_target;
            inflight <= 1'b0;
            stopped  <= 1'b0;
            halt     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= mem_rd;
            if (mem_rd) begin
                inflight_addr <= pc;
                pc            <= pc + ADDRSIZE'(1);
            end
            if (push) begin
                q_data[wr_ptr] <= mem_rdata;
                q_pc[wr_ptr]   <= inflight_addr;
                wr_ptr         <= wr_ptr + PW'(1);
                if (mem_rdata[WIDTH-1 -: 4] == OP_HLT) begin
                    stopped <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (ir[WIDTH-1 -: 4] == OP_HLT) begin
                    halt <= 1'b1;
                end
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_np_fetch.sv
// Directed bench for np_fetch: a one-cycle-latency memory model feeds the stage and
// each step compares outputs against hand-computed values.
module tb_np_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [11:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_taken;
    logic [11:0] br_target;
    logic        halt;

    logic [31:0] mem [4096];
    int compared = 0;
    int mismatched = 0;

    localparam logic [31:0] HLT_WORD = 32'hB000_0005;

    np_fetch #(.WIDTH(32), .ADDRSIZE(12), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .ir(ir),
        .ir_pc(ir_pc),
        .ir_valid(ir_valid),
        .ir_ready(ir_ready),
        .br_taken(br_taken),
        .br_target(br_target),
        .halt(halt)
    );

    always #5 clk = ~clk;

    // Memory returns the addressed word during the cycle after the request.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    function automatic logic [31:0] exp_word(input logic [11:0] a);
        return {4'h2, 16'hA5A5, a};
    endfunction

    task automatic apply_stimulus(input logic rst_level, input logic ready,
                                  input logic br, input logic [11:0] target);
        @(posedge clk);
        #1;
        reset     = rst_level;
        ir_ready  = ready;
        br_taken  = br;
        br_target = target;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        check_output({tag, " ir_valid"}, 32'(ir_valid), 32'd0);
        check_output({tag, " ir"}, ir, 32'd0);
        check_output({tag, " ir_pc"}, 32'(ir_pc), 32'd0);
        check_output({tag, " halt"}, 32'(halt), 32'd0);
    endtask

    task automatic check_head(input string tag, input logic [11:0] pc);
        check_output({tag, " valid"}, 32'(ir_valid), 32'd1);
        check_output({tag, " pc"}, 32'(ir_pc), 32'(pc));
        check_output({tag, " ir"}, ir, exp_word(pc));
    endtask

    initial begin
        reset = 1'b0;
        ir_ready = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = exp_word(12'(i));

        // Reset state, then streaming with ready held high.
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        check_reset_values("rst");
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("c0 mem_rd", 32'(mem_rd), 32'd1);
        check_output("c0 addr", 32'(mem_addr), 32'h000);
        check_output("c0 valid", 32'(ir_valid), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("c1 valid", 32'(ir_valid), 32'd0);
        check_output("c1 addr", 32'(mem_addr), 32'h001);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
            check_head("stream", 12'(i));
        end

        // Backpressure: two words outstanding/buffered, head held, then drained in order.
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);
        check_output("bp c1 mem_rd", 32'(mem_rd), 32'd1);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);
            check_head("bp hold", 12'h000);
            check_output("bp hold mem_rd", 32'(mem_rd), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
            check_head("bp drain", 12'(i));
            if (i == 0) check_output("bp resume addr", 32'(mem_addr), 32'h002);
        end

        // Branch to 0x100 with one word queued and one in flight.
        apply_stimulus(1'b0, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b0, 1'b1, 12'h100);
        check_output("br B mem_rd", 32'(mem_rd), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("br B+1 valid", 32'(ir_valid), 32'd0);
        check_output("br B+1 mem_rd", 32'(mem_rd), 32'd1);
        check_output("br B+1 addr", 32'(mem_addr), 32'h100);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("br B+2 valid", 32'(ir_valid), 32'd0);
        check_output("br B+2 addr", 32'(mem_addr), 32'h101);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
            check_head("br target", 12'(12'h100 + i));
        end

        // HLT at address 5 stops fetch; a branch to 0 clears halt and restarts.
        mem[5] = HLT_WORD;
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
            check_output("hlt req addr", 32'(mem_addr), 32'(i));
            check_output("hlt req mem_rd", 32'(mem_rd), 32'd1);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("hlt head pc", 32'(ir_pc), 32'h005);
        check_output("hlt head ir", ir, HLT_WORD);
        check_output("hlt c7 mem_rd", 32'(mem_rd), 32'd0);
        check_output("hlt c7 halt", 32'(halt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
            check_output("hlt stopped mem_rd", 32'(mem_rd), 32'd0);
            check_output("hlt halt", 32'(halt), 32'd1);
            if (i > 0) check_output("hlt drained valid", 32'(ir_valid), 32'd0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 12'h000);
        check_output("hlt br mem_rd", 32'(mem_rd), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("hlt restart halt", 32'(halt), 32'd0);
        check_output("hlt restart mem_rd", 32'(mem_rd), 32'd1);
        check_output("hlt restart addr", 32'(mem_addr), 32'h000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("hlt restart valid", 32'(ir_valid), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_head("hlt restart head", 12'h000);
        mem[5] = exp_word(12'h005);

        // Branch near the top of memory: PC wraps FFF -> 000.
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b1, 1'b1, 12'hFFE);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("wrap addr FFE", 32'(mem_addr), 32'hFFE);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("wrap addr FFF", 32'(mem_addr), 32'hFFF);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
            check_head("wrap", 12'(12'hFFE + i));
        end

        // Reset pulse mid-stream with a read in flight.
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_head("pre-reset", 12'h002);
        apply_stimulus(1'b0, 1'b1, 1'b0, 12'h000);
        check_reset_values("mid rst");
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("mid rst c0 addr", 32'(mem_addr), 32'h000);
        check_output("mid rst c0 mem_rd", 32'(mem_rd), 32'd1);
        check_output("mid rst c0 valid", 32'(ir_valid), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_output("mid rst c1 valid", 32'(ir_valid), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_head("mid rst c2", 12'h000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 12'h000);
        check_head("mid rst c3", 12'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
